// File: rtl/gpio_arb.sv
// gpio_arb: shares the GPIO register port between the core bus master (m0)
// and the debug/test master (m1). Supports plain reads and writes plus atomic
// bit-set / bit-clear, executed as an uninterrupted read-modify-write.
//
// Master handshake (both masters): a master raises mX_req_i with op/addr/data
// stable and holds it until mX_ack_o. The request fields are sampled only in
// the IDLE cycle in which that master is granted. mX_ack_o is a one-cycle
// pulse, and mX_data_o is valid in that cycle and holds until the next ack
// to the same master. A request still high during the ack cycle is treated
// as a new operation in the following IDLE cycle.
module gpio_arb #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req_i,
    input  logic [1:0]  m0_op_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_data_o,

    input  logic        m1_req_i,
    input  logic [1:0]  m1_op_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_data_o,

    output logic        gpio_we_o,
    output logic [31:0] gpio_addr_o,
    output logic [31:0] gpio_wdata_o,
    input  logic [31:0] gpio_rdata_i,

    output logic        busy_o,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    state_t      state;
    logic        last_gnt;   // 0 = m0 granted last, 1 = m1 granted last
    logic        gnt_id;     // master owning the operation in flight
    logic [1:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;     // write data or set/clear mask
    logic [31:0] rdata_q;    // value read in RD (0 for plain writes)
    logic [31:0] m0_data_q;
    logic [31:0] m1_data_q;

    logic        any_req;
    logic        win;        // 0 = m0, 1 = m1
    logic [1:0]  sel_op;
    logic [31:0] sel_addr;
    logic [31:0] sel_data;
    logic [31:0] wr_value;

    // Pick the winning master for this IDLE cycle and mux its request fields.
    always_comb begin
        any_req  = m0_req_i | m1_req_i;
        win      = 1'b0;
        if (m0_req_i && m1_req_i) begin
            // Tie: round-robin favours whoever was not granted last;
            // fixed priority always favours m0.
            win = RR_EN ? ~last_gnt : 1'b0;
        end else if (m1_req_i) begin
            win = 1'b1;
        end
        sel_op   = win ? m1_op_i   : m0_op_i;
        sel_addr = win ? m1_addr_i : m0_addr_i;
        sel_data = win ? m1_data_i : m0_data_i;
    end

    // Value presented on the GPIO write port for the latched operation.
    always_comb begin
        wr_value = data_q;
        case (op_q)
            OP_SET:   wr_value = rdata_q | data_q;
            OP_CLEAR: wr_value = rdata_q & ~data_q;
            default:  wr_value = data_q;
        endcase
    end

    // Sequencer: grant, read, write, acknowledge. Once granted, the other
    // master cannot get in until the ACK state has passed, which keeps
    // set/clear read-modify-writes atomic on the GPIO port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            last_gnt  <= 1'b1;
            gnt_id    <= 1'b0;
            op_q      <= OP_READ;
            addr_q    <= '0;
            data_q    <= '0;
            rdata_q   <= '0;
            m0_data_q <= '0;
            m1_data_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        gnt_id   <= win;
                        last_gnt <= win;
                        op_q     <= sel_op;
                        addr_q   <= sel_addr;
                        data_q   <= sel_data;
                        rdata_q  <= '0;
                        state    <= (sel_op == OP_WRITE) ? S_WR : S_RD;
                    end
                end
                S_RD: begin
                    rdata_q <= gpio_rdata_i;
                    if (op_q == OP_READ) begin
                        // Plain read: return the sampled value straight away.
                        if (gnt_id) m1_data_q <= gpio_rdata_i;
                        else        m0_data_q <= gpio_rdata_i;
                        state <= S_ACK;
                    end else begin
                        state <= S_WR;
                    end
                end
                S_WR: begin
                    // Plain writes return 0 (rdata_q cleared at grant);
                    // set/clear return the pre-modification value.
                    if (gnt_id) m1_data_q <= rdata_q;
                    else        m0_data_q <= rdata_q;
                    state <= S_ACK;
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from registers only, so reset clears them at once.
    always_comb begin
        gpio_we_o    = (state == S_WR);
        gpio_addr_o  = addr_q;
        gpio_wdata_o = (state == S_WR) ? wr_value : 32'd0;
        m0_ack_o     = (state == S_ACK) && !gnt_id;
        m1_ack_o     = (state == S_ACK) &&  gnt_id;
        m0_data_o    = m0_data_q;
        m1_data_o    = m1_data_q;
        busy_o       = (state != S_IDLE);
        dbg_state_o  = state;
    end

endmodule

// File: tb/tb_gpio_arb.sv
// Bench for gpio_arb: directed vector table, hand-written multi-cycle
// sequences, and randomized single/dual-master rounds against a
// memory-level reference model.
module tb_gpio_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req  [2];
    logic [1:0]  op   [2];
    logic [31:0] addr [2];
    logic [31:0] wd   [2];

    // Round-robin instance (main DUT)
    logic        ack_a  [2];
    logic [31:0] dout_a [2];
    logic        gpio_we, busy;
    logic [31:0] gpio_addr, gpio_wdata, gpio_rdata;
    logic [1:0]  dbg_state;

    // Fixed-priority instance (used for the contention comparison)
    logic        ack_b  [2];
    logic [31:0] dout_b [2];
    logic        b_we, b_busy;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [1:0]  b_state;

    always #5 clk = ~clk;

    gpio_arb #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(req[0]), .m0_op_i(op[0]), .m0_addr_i(addr[0]), .m0_data_i(wd[0]),
        .m0_ack_o(ack_a[0]), .m0_data_o(dout_a[0]),
        .m1_req_i(req[1]), .m1_op_i(op[1]), .m1_addr_i(addr[1]), .m1_data_i(wd[1]),
        .m1_ack_o(ack_a[1]), .m1_data_o(dout_a[1]),
        .gpio_we_o(gpio_we), .gpio_addr_o(gpio_addr), .gpio_wdata_o(gpio_wdata),
        .gpio_rdata_i(gpio_rdata), .busy_o(busy), .dbg_state_o(dbg_state)
    );

    gpio_arb #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req_i(req[0]), .m0_op_i(op[0]), .m0_addr_i(addr[0]), .m0_data_i(wd[0]),
        .m0_ack_o(ack_b[0]), .m0_data_o(dout_b[0]),
        .m1_req_i(req[1]), .m1_op_i(op[1]), .m1_addr_i(addr[1]), .m1_data_i(wd[1]),
        .m1_ack_o(ack_b[1]), .m1_data_o(dout_b[1]),
        .gpio_we_o(b_we), .gpio_addr_o(b_addr), .gpio_wdata_o(b_wdata),
        .gpio_rdata_i(b_rdata), .busy_o(b_busy), .dbg_state_o(b_state)
    );

    // GPIO register file model: four registers selected by addr[3:2]
    logic [31:0] gmem [4];
    assign gpio_rdata = gmem[gpio_addr[3:2]];
    assign b_rdata    = gmem[b_addr[3:2]];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) gmem[i] <= 32'd0;
        end else if (gpio_we) begin
            gmem[gpio_addr[3:2]] <= gpio_wdata;
        end
    end

    // Bus monitors, sampled on the falling edge
    int          we_cnt = 0;
    logic [31:0] last_wdata = 32'd0;
    logic [31:0] last_waddr = 32'd0;
    int          ack_q  [$];
    int          ackb_q [$];
    logic        dual_ack = 1'b0;

    always @(negedge clk) begin
        if (gpio_we) begin
            we_cnt     <= we_cnt + 1;
            last_wdata <= gpio_wdata;
            last_waddr <= gpio_addr;
        end
        if (ack_a[0]) ack_q.push_back(0);
        if (ack_a[1]) ack_q.push_back(1);
        if (ack_b[0]) ackb_q.push_back(0);
        if (ack_b[1]) ackb_q.push_back(1);
        if (ack_a[0] && ack_a[1]) dual_ack <= 1'b1;
    end

    // Scoreboard
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: GPIO register contents and the arbiter's tie memory
    logic [31:0] mm [4];
    int          model_last;

    function automatic logic [31:0] model_op(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] d);
        logic [31:0] old;
        old = mm[a[3:2]];
        case (o)
            2'b00: return old;
            2'b01: begin mm[a[3:2]] = d; return 32'd0; end
            2'b10: begin mm[a[3:2]] = old | d; return old; end
            default: begin mm[a[3:2]] = old & ~d; return old; end
        endcase
    endfunction

    function automatic int op_lat(input logic [1:0] o);
        return (o == 2'b00 || o == 2'b01) ? 2 : 3;
    endfunction

    // Driver: issue one operation from master m and wait (bounded) for its ack.
    // Returns read data and the number of clock edges from request to ack.
    task automatic mop(input int m, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output int cyc);
        req[m] = 1'b1; op[m] = o; addr[m] = a; wd[m] = d;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!ack_a[m] && cyc < 20);
        rd = dout_a[m];
        req[m] = 1'b0;
    endtask

    typedef struct {
        int          m;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          exp_we;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t        vt [10];
    logic [31:0] rd, rd0, rd1, e0, e1;
    int          cyc, c0, c1, base_we, base_ack, base_ackb, lat0, lat1, w;
    logic [1:0]  o0, o1;
    logic [31:0] a0, a1, d0, d1;

    initial begin
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; op[i] = 2'b00; addr[i] = 32'd0; wd[i] = 32'd0;
        end
        for (int i = 0; i < 4; i++) mm[i] = 32'd0;
        model_last = 1;

        // ---- clock / reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we",     32'(gpio_we), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_addr",  gpio_addr, 32'd0);
        chk("reset_wdata", gpio_wdata, 32'd0);
        chk("reset_ack0",  32'(ack_a[0]), 32'd0);
        chk("reset_ack1",  32'(ack_a[1]), 32'd0);
        chk("reset_dout0", dout_a[0], 32'd0);
        chk("reset_dout1", dout_a[1], 32'd0);
        chk("reset_state", 32'(dbg_state), 32'd0);

        // ---- directed vector table
        vt[0] = '{0, 2'b01, 32'h0000_0004, 32'h0000_00A5, 32'h0,         2, 1, 32'h0000_00A5};
        vt[1] = '{0, 2'b00, 32'h0000_0004, 32'h0,         32'h0000_00A5, 2, 0, 32'h0};
        vt[2] = '{1, 2'b01, 32'h0000_0004, 32'h0000_0F00, 32'h0,         2, 1, 32'h0000_0F00};
        vt[3] = '{1, 2'b10, 32'h0000_0004, 32'h0000_0011, 32'h0000_0F00, 3, 1, 32'h0000_0F11};
        vt[4] = '{0, 2'b00, 32'h0000_0004, 32'h0,         32'h0000_0F11, 2, 0, 32'h0};
        vt[5] = '{0, 2'b01, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0,         2, 1, 32'hFFFF_FFFF};
        vt[6] = '{1, 2'b11, 32'h0000_0000, 32'h0000_FF00, 32'hFFFF_FFFF, 3, 1, 32'hFFFF_00FF};
        vt[7] = '{1, 2'b00, 32'h0000_0000, 32'h0,         32'hFFFF_00FF, 2, 0, 32'h0};
        vt[8] = '{0, 2'b01, 32'h1000_000C, 32'hDEAD_BEEF, 32'h0,         2, 1, 32'hDEAD_BEEF};
        vt[9] = '{1, 2'b00, 32'hABC0_000C, 32'h0,         32'hDEAD_BEEF, 2, 0, 32'h0};

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            base_we = we_cnt;
            mop(vt[i].m, vt[i].op, vt[i].a, vt[i].d, rd, cyc);
            void'(model_op(vt[i].op, vt[i].a, vt[i].d));
            model_last = vt[i].m;
            chk($sformatf("vec%0d_data", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_lat", i), 32'(cyc), 32'(vt[i].exp_lat));
            chk($sformatf("vec%0d_wecnt", i), 32'(we_cnt - base_we), 32'(vt[i].exp_we));
            if (vt[i].exp_we != 0) begin
                chk($sformatf("vec%0d_wdata", i), last_wdata, vt[i].exp_wd);
                chk($sformatf("vec%0d_waddr", i), last_waddr, vt[i].a);
            end
        end

        // ---- queued request: m0 holds req through ACK with a new write
        @(posedge clk); #1;
        req[0] = 1'b1; op[0] = 2'b00; addr[0] = 32'h4; wd[0] = 32'h0;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!ack_a[0] && cyc < 20);
        chk("queue_rd_data", dout_a[0], model_op(2'b00, 32'h4, 32'h0));
        op[0] = 2'b01; wd[0] = 32'h0000_5678;
        @(posedge clk); #1;
        chk("queue_idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("queue_wr_busy", 32'(busy), 32'd1);
        chk("queue_wr_we", 32'(gpio_we), 32'd1);
        chk("queue_wr_wdata", gpio_wdata, 32'h0000_5678);
        @(posedge clk); #1;
        chk("queue_ack", 32'(ack_a[0]), 32'd1);
        chk("queue_wr_ret", dout_a[0], model_op(2'b01, 32'h4, 32'h0000_5678));
        req[0] = 1'b0;
        model_last = 0;

        // ---- reset during the WR of a set operation
        @(posedge clk); #1;
        req[0] = 1'b1; op[0] = 2'b10; addr[0] = 32'h4; wd[0] = 32'h0000_0001;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!gpio_we && cyc < 10);
        chk("rst_mid_reach_wr", 32'(gpio_we), 32'd1);
        base_we  = we_cnt;
        base_ack = ack_q.size();
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_we",    32'(gpio_we), 32'd0);
        chk("rst_mid_busy",  32'(busy), 32'd0);
        chk("rst_mid_addr",  gpio_addr, 32'd0);
        chk("rst_mid_wdata", gpio_wdata, 32'd0);
        chk("rst_mid_dout0", dout_a[0], 32'd0);
        chk("rst_mid_dout1", dout_a[1], 32'd0);
        req[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) mm[i] = 32'd0;
        model_last = 1;
        @(posedge clk); #1;
        chk("rst_mid_no_we",  32'(we_cnt - base_we), 32'd0);
        chk("rst_mid_no_ack", 32'(ack_q.size() - base_ack), 32'd0);

        // ---- contention: both masters hold read requests for 4 operations
        base_ack  = ack_q.size();
        base_ackb = ackb_q.size();
        req[0] = 1'b1; op[0] = 2'b00; addr[0] = 32'h0;
        req[1] = 1'b1; op[1] = 2'b00; addr[1] = 32'h4;
        repeat (12) @(posedge clk);
        #1;
        req[0] = 1'b0; req[1] = 1'b0;
        chk("rr_ack_count", 32'(ack_q.size() - base_ack), 32'd4);
        chk("fp_ack_count", 32'(ackb_q.size() - base_ackb), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (base_ack + k < ack_q.size())
                chk($sformatf("rr_grant%0d", k), 32'(ack_q[base_ack + k]), 32'(k % 2));
            if (base_ackb + k < ackb_q.size())
                chk($sformatf("fp_grant%0d", k), 32'(ackb_q[base_ackb + k]), 32'd0);
        end
        model_last = 1;
        repeat (2) @(posedge clk);

        // ---- randomized rounds against the reference model
        for (int r = 0; r < 40; r++) begin
            int mode;
            mode = $urandom_range(0, 2);
            o0 = 2'($urandom_range(0, 3));
            o1 = 2'($urandom_range(0, 3));
            a0 = ($urandom & 32'hFFFF_FFF0) | (32'($urandom_range(0, 3)) << 2);
            a1 = ($urandom & 32'hFFFF_FFF0) | (32'($urandom_range(0, 3)) << 2);
            d0 = $urandom;
            d1 = $urandom;
            e0 = 32'd0; e1 = 32'd0; lat0 = 0; lat1 = 0; w = 0;
            if (mode == 0) begin
                e0 = model_op(o0, a0, d0); lat0 = op_lat(o0); model_last = 0;
            end else if (mode == 1) begin
                e1 = model_op(o1, a1, d1); lat1 = op_lat(o1); model_last = 1;
            end else begin
                w = 1 - model_last;
                if (w == 0) begin
                    e0 = model_op(o0, a0, d0);
                    e1 = model_op(o1, a1, d1);
                    lat0 = op_lat(o0);
                    lat1 = op_lat(o0) + 1 + op_lat(o1);
                end else begin
                    e1 = model_op(o1, a1, d1);
                    e0 = model_op(o0, a0, d0);
                    lat1 = op_lat(o1);
                    lat0 = op_lat(o1) + 1 + op_lat(o0);
                end
                model_last = 1 - w;
            end

            @(posedge clk); #1;
            base_ack = ack_q.size();
            fork
                begin if (mode != 1) mop(0, o0, a0, d0, rd0, c0); end
                begin if (mode != 0) mop(1, o1, a1, d1, rd1, c1); end
            join

            if (mode != 1) begin
                chk($sformatf("rnd%0d_m0_data", r), rd0, e0);
                chk($sformatf("rnd%0d_m0_lat", r), 32'(c0), 32'(lat0));
            end
            if (mode != 0) begin
                chk($sformatf("rnd%0d_m1_data", r), rd1, e1);
                chk($sformatf("rnd%0d_m1_lat", r), 32'(c1), 32'(lat1));
            end
            if (mode == 2 && base_ack < ack_q.size())
                chk($sformatf("rnd%0d_first_grant", r), 32'(ack_q[base_ack]), 32'(w));
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++)
                chk($sformatf("rnd%0d_mem%0d", r, i), gmem[i], mm[i]);
        end

        chk("no_dual_ack", 32'(dual_ack), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gpio_arb.md
# gpio_arb

Two-master arbiter and sequencer for the GPIO register port (`we_i`/`addr_i`/`data_i`/`data_o`). It shares the port between the core bus master (m0) and the debug/test master (m1). Each master may issue plain reads and writes, or atomic bit-set and bit-clear operations. For set/clear, the block executes the read-modify-write on the GPIO port with no interleaving from the other master.

## Interface
- `RR_EN`, default 1: 1 = round-robin between m0 and m1; 0 = fixed priority, m0 wins.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `m0_req_i`  in  1  m0 request; held high until `m0_ack_o`.
- `m0_op_i`  in  2  00 read, 01 write, 10 set bits, 11 clear bits.
- `m0_addr_i`  in  32  GPIO register address (0x0 ctrl, 0x4 data).
- `m0_data_i`  in  32  write data, or set/clear mask.
- `m0_ack_o`  out  1  one-cycle completion pulse.
- `m0_data_o`  out  32  read data. For set/clear, the value before modification.
- `m1_req_i`, `m1_op_i`, `m1_addr_i`, `m1_data_i`, `m1_ack_o`, `m1_data_o`: same as m0.
- `gpio_we_o`  out  1  write enable to the GPIO port.
- `gpio_addr_o`  out  32  address to the GPIO port.
- `gpio_wdata_o`  out  32  write data to the GPIO port.
- `gpio_rdata_i`  in  32  combinational read data from the GPIO port.
- `busy_o`  out  1  high whenever the state is not IDLE.

## Operation
- **States:** IDLE, RD, WR, ACK.
- **IDLE:**
  - If any request is high, select a winner and latch its op, addr, data and id.
  - Next state: RD for op 00/10/11, WR for op 01.
  - Requester fields are sampled only in the grant cycle.
- **RD:**
  - `gpio_we_o`=0 and `gpio_addr_o`=latched addr.
  - At the clock edge, capture `gpio_rdata_i` into the rdata register.
  - Next state: ACK for op 00, WR for op 10/11.
- **WR:** `gpio_we_o`=1 and `gpio_addr_o`=latched addr. `gpio_wdata_o` is:
  - latched data for op 01;
  - rdata | mask for op 10;
  - rdata & ~mask for op 11.
  - Next state: ACK.
- **ACK:**
  - Assert `mX_ack_o` for the granted master only.
  - `mX_data_o` = rdata. For op 01, rdata is 0.
  - Next state: IDLE, unconditionally. A master may hold req high through ACK to queue its next operation; that operation is evaluated in the following IDLE cycle.
- **Arbitration:**
  - With `RR_EN`=1, when both masters request, grant the master not granted last.
  - A single requester is always granted.
  - The last-grant register resets to m1, so m0 wins the first tie.
  - With `RR_EN`=0, m0 always wins a tie.
- **Atomicity:** the other master is never granted between RD and WR of a set/clear. Input-pin sampling by the GPIO block between RD and WR is not protected and is accepted.
- **Out-of-range addresses:** no decode or check. The full 32-bit address passes through unchanged.

## Timing
- **Reset values:**
  - State = IDLE, last-grant = m1.
  - `gpio_we_o`=0, `gpio_addr_o`=0, `gpio_wdata_o`=0.
  - Both acks 0, both data outputs 0, `busy_o`=0.
- **Latency from the grant cycle (IDLE, with req high) to the ack cycle:**
  - read: 2 cycles (IDLE→RD→ACK);
  - write: 2 cycles (IDLE→WR→ACK);
  - set/clear: 3 cycles (IDLE→RD→WR→ACK).
- **Back-to-back throughput:**
  - read and write: one operation per 3 cycles;
  - set/clear: one operation per 4 cycles.
- **`gpio_we_o`:** decoded from the state register, high only in WR, exactly one cycle per write-type op.
- **`mX_ack_o`, `mX_data_o`:** decoded from registers; `mX_data_o` holds its value until the next ACK of that master.
- **Reset asserted mid-operation:** state returns to IDLE immediately and asynchronously, and `gpio_we_o` drops in the same cycle. No ack is issued for the aborted op. A requester must re-issue after reset.
- **Request dropped before ack:** protocol violation. The block still completes the latched operation and pulses ack.

## Test plan
- **m0 write then read back:** m0 write addr 0x4, data 0x0000_00A5, then read 0x4 (GPIO model returns 0xA5).
  - `gpio_we_o` is high for exactly 1 cycle with wdata 0xA5.
  - The read ack arrives 2 cycles after grant with `m0_data_o`=0xA5.
- **m1 set bits:** GPIO data = 0x0000_0F00; m1 op 10, mask 0x0000_0011.
  - RD, then WR with wdata 0x0000_0F11.
  - Ack 3 cycles after grant; `m1_data_o`=0x0000_0F00.
- **Clear bits:** data = 0xFFFF_FFFF; op 11, mask 0x0000_FF00.
  - wdata 0xFFFF_00FF.
- **Contention with `RR_EN`=1:** m0 and m1 both hold read requests continuously.
  - Grants are m0, m1, m0, m1.
  - No grant switches between RD and WR of a set/clear.
  - With `RR_EN`=0, m0 wins every time.
- **Reset mid-operation:** assert `rst` during the WR of a set op.
  - `gpio_we_o` goes to 0 the same cycle, there is no ack, and all outputs return to 0.
  - After release, the first tie goes to m0.
- **Queued request from the same master:** m0 holds req through ACK with a new write.
  - The next grant occurs in the following IDLE cycle; `busy_o` is low for exactly that cycle.
